alu_arbiter: RTL and testbench
==============================

ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 SHALL have parameter: DATA_W, 32, operand/result width.
REQ-002 SHALL have port: clk  input  1  single clock, all state on rising edge.
REQ-003 SHALL have port: nRst  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have ports: reqN_valid  input  1  requester N (N=0,1) has an operation pending.
REQ-005 SHALL have ports: reqN_ready  output  1  arbiter accepts requester N this cycle.
REQ-006 SHALL have ports: reqN_op  input  4  ALU opcode (0 ADD, 1 SUB, 2 OR, 3 XOR, 4 AND, 5 SLL, 6 SRA, 7 SLTU, 8 SLT, 9 SRL).
REQ-007 SHALL have ports: reqN_a, reqN_b  input  DATA_W  operands.
REQ-008 SHALL have ports: alu_op  output  4,  alu_a / alu_b  output  DATA_W  registered drive to the shared ALU.
REQ-009 SHALL have ports: alu_result  input  DATA_W,  alu_negative / alu_zero  input  1  combinational ALU return.
REQ-010 SHALL have ports: rspN_valid  output  1,  rspN_ready  input  1  response handshake per requester.
REQ-011 SHALL have ports: rspN_result  output  DATA_W,  rspN_flags  output  2  ({negative, zero}).

Function
REQ-012 SHALL implement FSM IDLE -> ISSUE -> RESP -> IDLE, one operation in flight.
REQ-013 IDLE: if any reqN_valid, SHALL select a winner, assert only winner's reqN_ready (combinational), latch op/a/b into alu_op/alu_a/alu_b, record owner, go ISSUE; else stay.
REQ-014 reqN_ready SHALL be high only in IDLE and only for the winner; never both.
REQ-015 ISSUE: SHALL hold alu_* stable and capture alu_result, alu_negative, alu_zero into result register at clock edge; go RESP.
REQ-016 RESP: SHALL assert rspN_valid for owner only, with registered result/flags; hold valid and data stable until rspN_ready high; on handshake go IDLE.
REQ-017 Latency: accept at edge k SHALL give rspN_valid high from cycle k+2; minimum issue interval 3 cycles with rspN_ready tied high.
REQ-018 Arbitration (default): round-robin; on simultaneous valids SHALL grant the requester not granted last; single valid SHALL be granted regardless of pointer.
REQ-019 Round-robin pointer SHALL update only on accept (reqN_valid & reqN_ready).
REQ-020 Opcodes 10-15 SHALL be forwarded unchanged; response carries whatever ALU returns (0, flags 00).
REQ-021 Requests arriving in ISSUE/RESP SHALL be ignored until IDLE; requesters hold valid and payload until ready.
REQ-022 rspN_ready asserted while rspN_valid low SHALL have no effect.
REQ-023 Non-owner rsp outputs SHALL read valid 0; rspN_result/flags of non-owner unspecified.

Reset
REQ-024 nRst low SHALL asynchronously force IDLE, alu_op 0, alu_a/alu_b 0, result/flags 0, all reqN_ready and rspN_valid 0, pointer = last-granted 1 (req0 wins first tie).
REQ-025 Reset mid-operation SHALL discard in-flight operation; no response after release.
REQ-026 First accept SHALL be possible on first rising edge after nRst deasserts.

Configuration
REQ-027 Macro ALU_ARB_FIXED_PRIO_EN: when defined, SHALL use fixed priority (req0 always wins ties) and no round-robin pointer; when undefined, round-robin per REQ-018/019.

Verification
REQ-028 req0 ADD a=5 b=7 alone -> req0_ready one cycle, alu_a=5/alu_b=7 in ISSUE, rsp0_valid two cycles later, rsp0_result 12, flags 00.
REQ-029 Out of reset, req0 SUB 3,3 and req1 OR 0xF0,0x0F together -> req0 first: result 0, flags 01; then req1: result 0xFF, flags 00.
REQ-030 Both valid continuously, 4 ops, rsp ready high -> grant order 0,1,0,1; with ALU_ARB_FIXED_PRIO_EN -> 0,0,0,0.
REQ-031 rsp0_ready low 4 cycles in RESP -> rsp0_valid and rsp0_result stable; req1_ready stays 0 throughout; accepted after handshake.
REQ-032 req1 SLT a=0xFFFFFFFF b=1 -> rsp1_result 1; SLTU same operands -> 0.
REQ-033 nRst pulsed low during ISSUE -> all outputs 0 immediately; no rspN_valid after release until a new request.

Source files
------------

// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one combinational ALU between two requesters, one operation in flight.
// Build option: define ALU_ARB_FIXED_PRIO_EN for fixed priority (req0 wins ties) instead of round-robin.
//
// state | meaning
// IDLE  | waiting for a request; winner sees ready, its op/operands are latched
// ISSUE | operands held on alu_*; ALU return captured at the end of the cycle
// RESP  | owner sees rsp valid with registered result/flags until it takes them

module alu_arbiter #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              nRst,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [3:0]        req0_op,
    input  logic [DATA_W-1:0] req0_a,
    input  logic [DATA_W-1:0] req0_b,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [3:0]        req1_op,
    input  logic [DATA_W-1:0] req1_a,
    input  logic [DATA_W-1:0] req1_b,
    output logic [3:0]        alu_op,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    input  logic [DATA_W-1:0] alu_result,
    input  logic              alu_negative,
    input  logic              alu_zero,
    output logic              rsp0_valid,
    input  logic              rsp0_ready,
    output logic [DATA_W-1:0] rsp0_result,
    output logic [1:0]        rsp0_flags,
    output logic              rsp1_valid,
    input  logic              rsp1_ready,
    output logic [DATA_W-1:0] rsp1_result,
    output logic [1:0]        rsp1_flags
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_t;

    state_t            state;
    state_t            next_state;
    logic              owner;
    logic              grant0;
    logic              grant1;
    logic              accept;
    logic              rsp_done;
    logic [DATA_W-1:0] result_q;
    logic [1:0]        flags_q;

`ifndef ALU_ARB_FIXED_PRIO_EN
    logic              last_grant;
`endif

    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (req0_valid && req1_valid) begin
`ifdef ALU_ARB_FIXED_PRIO_EN
            grant0 = 1'b1;
`else
            grant0 = last_grant;
            grant1 = !last_grant;
`endif
        end else begin
            grant0 = req0_valid;
            grant1 = req1_valid;
        end
    end

    // ready is gated by nRst so nothing is offered while reset is held
    assign accept   = (state == IDLE) && nRst && (grant0 || grant1);
    assign rsp_done = owner ? rsp1_ready : rsp0_ready;

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (accept) next_state = ISSUE;
            ISSUE:   next_state = RESP;
            RESP:    if (rsp_done) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        rsp0_valid = 1'b0;
        rsp1_valid = 1'b0;
        if (state == IDLE && nRst) begin
            req0_ready = grant0;
            req1_ready = grant1;
        end
        if (state == RESP) begin
            rsp0_valid = !owner;
            rsp1_valid = owner;
        end
    end

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            alu_op   <= 4'd0;
            alu_a    <= '0;
            alu_b    <= '0;
            owner    <= 1'b0;
            result_q <= '0;
            flags_q  <= 2'b00;
        end else begin
            if (accept) begin
                alu_op <= grant1 ? req1_op : req0_op;
                alu_a  <= grant1 ? req1_a  : req0_a;
                alu_b  <= grant1 ? req1_b  : req0_b;
                owner  <= grant1;
            end
            if (state == ISSUE) begin
                result_q <= alu_result;
                flags_q  <= {alu_negative, alu_zero};
            end
        end
    end

`ifndef ALU_ARB_FIXED_PRIO_EN
    // reset value 1 makes req0 the first tie winner
    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            last_grant <= 1'b1;
        end else if (accept) begin
            last_grant <= grant1;
        end
    end
`endif

    assign rsp0_result = result_q;
    assign rsp1_result = result_q;
    assign rsp0_flags  = flags_q;
    assign rsp1_flags  = flags_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: models the shared ALU, scoreboards accepted requests against responses.
module tb_alu_arbiter;
    localparam int W = 32;

    logic clk = 1'b0;
    logic nRst = 1'b0;
    logic req0_valid, req0_ready, req1_valid, req1_ready;
    logic [3:0] req0_op, req1_op, alu_op;
    logic [W-1:0] req0_a, req0_b, req1_a, req1_b, alu_a, alu_b, alu_result;
    logic alu_negative, alu_zero;
    logic rsp0_valid, rsp0_ready, rsp1_valid, rsp1_ready;
    logic [W-1:0] rsp0_result, rsp1_result;
    logic [1:0] rsp0_flags, rsp1_flags;

    typedef struct packed { logic [3:0] op; logic [W-1:0] a; logic [W-1:0] b; } op_t;
    typedef struct packed { logic owner; logic [1:0] flags; logic [W-1:0] result; } ent_t;

    op_t  q0[$], q1[$];
    ent_t exp_q[$], got_q[$];
    int   grant_q[$];
    int   exp_rd = 0, got_rd = 0, g_rd = 0;
    int   acc_cnt0 = 0, acc_cnt1 = 0, pop0 = 0, pop1 = 0;
    int   both_ready = 0;
    int   checks = 0, failures = 0;
    ent_t mon_e;

    always #5 clk = ~clk;

    function automatic logic [W+1:0] alu_ref(input logic [3:0] op, input logic [W-1:0] a,
                                             input logic [W-1:0] b);
        logic [W-1:0] r;
        r = '0;
        case (op)
            4'd0: r = a + b;
            4'd1: r = a - b;
            4'd2: r = a | b;
            4'd3: r = a ^ b;
            4'd4: r = a & b;
            4'd5: r = a << b[4:0];
            4'd6: r = $signed(a) >>> b[4:0];
            4'd7: r = (a < b) ? W'(1) : '0;
            4'd8: r = ($signed(a) < $signed(b)) ? W'(1) : '0;
            4'd9: r = a >> b[4:0];
            default: return '0;
        endcase
        return {r[W-1], (r == '0), r};
    endfunction

    assign {alu_negative, alu_zero, alu_result} = alu_ref(alu_op, alu_a, alu_b);

    alu_arbiter #(.DATA_W(W)) dut (
        .clk(clk), .nRst(nRst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
        .req0_a(req0_a), .req0_b(req0_b),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
        .req1_a(req1_a), .req1_b(req1_b),
        .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b),
        .alu_result(alu_result), .alu_negative(alu_negative), .alu_zero(alu_zero),
        .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_result(rsp0_result),
        .rsp0_flags(rsp0_flags),
        .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_result(rsp1_result),
        .rsp1_flags(rsp1_flags)
    );

    // accepts push the expected response; handshakes record the observed one
    always @(negedge clk) begin
        if (nRst === 1'b1) begin
            if (req0_ready && req1_ready) both_ready++;
            if (req0_valid && req0_ready) begin
                mon_e = {1'b0, alu_ref(req0_op, req0_a, req0_b)};
                exp_q.push_back(mon_e);
                grant_q.push_back(0);
                acc_cnt0++;
            end
            if (req1_valid && req1_ready) begin
                mon_e = {1'b1, alu_ref(req1_op, req1_a, req1_b)};
                exp_q.push_back(mon_e);
                grant_q.push_back(1);
                acc_cnt1++;
            end
            if (rsp0_valid && rsp0_ready) got_q.push_back({1'b0, rsp0_flags, rsp0_result});
            if (rsp1_valid && rsp1_ready) got_q.push_back({1'b1, rsp1_flags, rsp1_result});
        end
    end

    task automatic apply();
        req0_valid = (q0.size() > 0);
        req1_valid = (q1.size() > 0);
        if (q0.size() > 0) {req0_op, req0_a, req0_b} = q0[0];
        else {req0_op, req0_a, req0_b} = '0;
        if (q1.size() > 0) {req1_op, req1_a, req1_b} = q1[0];
        else {req1_op, req1_a, req1_b} = '0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        while (pop0 < acc_cnt0) begin
            if (q0.size() > 0) void'(q0.pop_front());
            pop0++;
        end
        while (pop1 < acc_cnt1) begin
            if (q1.size() > 0) void'(q1.pop_front());
            pop1++;
        end
        apply();
    endtask

    task automatic do_reset();
        nRst = 1'b0;
        q0.delete();
        q1.delete();
        pop0 = acc_cnt0;
        pop1 = acc_cnt1;
        apply();
        rsp0_ready = 1'b1;
        rsp1_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        exp_rd = exp_q.size();
        got_rd = got_q.size();
        g_rd   = grant_q.size();
        nRst = 1'b1;
    endtask

    task automatic wait_resp(input int n, input int budget, output bit ok);
        for (int i = 0; i < budget && (got_q.size() - got_rd) < n; i++) step();
        ok = (got_q.size() - got_rd) >= n;
    endtask

    task automatic test_reset();
        nRst = 1'b0;
        rsp0_ready = 1'b1;
        rsp1_ready = 1'b1;
        q0.push_back({4'd3, 32'h1234_5678, 32'h0000_00FF});
        apply();
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({alu_op, alu_a, alu_b} !== '0) begin
            failures++;
            $display("FAIL reset_alu got op=%h a=%h b=%h want all 0", alu_op, alu_a, alu_b);
        end
        checks++;
        if ({req0_ready, req1_ready, rsp0_valid, rsp1_valid} !== 4'b0000) begin
            failures++;
            $display("FAIL reset_handshake got rdy=%b%b vld=%b%b want 0000",
                     req0_ready, req1_ready, rsp0_valid, rsp1_valid);
        end
        checks++;
        if ({rsp0_result, rsp0_flags} !== '0) begin
            failures++;
            $display("FAIL reset_result got %h/%b want 0/00", rsp0_result, rsp0_flags);
        end
        do_reset();
    endtask

    task automatic test_single_add();
        ent_t g;
        do_reset();
        q0.push_back({4'd0, 32'd5, 32'd7});
        apply();
        #1;
        checks++;
        if ({req0_ready, req1_ready} !== 2'b10) begin
            failures++;
            $display("FAIL add_ready got %b%b want 10", req0_ready, req1_ready);
        end
        step();
        checks++;
        if ({alu_op, alu_a, alu_b, req0_ready, rsp0_valid} !== {4'd0, 32'd5, 32'd7, 2'b00}) begin
            failures++;
            $display("FAIL add_issue got op=%h a=%0d b=%0d rdy=%b vld=%b want 0/5/7/0/0",
                     alu_op, alu_a, alu_b, req0_ready, rsp0_valid);
        end
        step();
        checks++;
        if ({rsp0_valid, rsp1_valid, rsp0_result, rsp0_flags} !== {2'b10, 32'd12, 2'b00}) begin
            failures++;
            $display("FAIL add_resp got vld=%b%b res=%0d flags=%b want 10/12/00",
                     rsp0_valid, rsp1_valid, rsp0_result, rsp0_flags);
        end
        step();
        checks++;
        if (rsp0_valid !== 1'b0 || got_q.size() - got_rd != 1) begin
            failures++;
            $display("FAIL add_done got vld=%b responses=%0d want 0/1", rsp0_valid,
                     got_q.size() - got_rd);
        end
        if (got_q.size() > got_rd) begin
            g = got_q[got_rd];
            got_rd++;
            exp_rd++;
            g_rd++;
            checks++;
            if (g !== {1'b0, 2'b00, 32'd12}) begin
                failures++;
                $display("FAIL add_sb got %h want %h", g, {1'b0, 2'b00, 32'd12});
            end
        end
    endtask

    task automatic test_tie();
        ent_t want[2];
        bit ok;
        want[0] = {1'b0, 2'b01, 32'h0};
        want[1] = {1'b1, 2'b00, 32'hFF};
        do_reset();
        q0.push_back({4'd1, 32'd3, 32'd3});
        q1.push_back({4'd2, 32'hF0, 32'h0F});
        apply();
        #1;
        checks++;
        if ({req0_ready, req1_ready} !== 2'b10) begin
            failures++;
            $display("FAIL tie_first_ready got %b%b want 10", req0_ready, req1_ready);
        end
        wait_resp(2, 40, ok);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL tie_timeout got %0d responses want 2", got_q.size() - got_rd);
        end
        for (int i = 0; i < 2 && got_rd < got_q.size(); i++) begin
            checks++;
            if (got_q[got_rd] !== want[i] || exp_q[exp_rd] !== want[i]) begin
                failures++;
                $display("FAIL tie_resp%0d got %h sb %h want %h", i, got_q[got_rd],
                         exp_q[exp_rd], want[i]);
            end
            got_rd++;
            exp_rd++;
        end
        g_rd = grant_q.size();
    endtask

    task automatic test_round_robin();
        logic [3:0] ops0[4] = '{4'd0, 4'd5, 4'd12, 4'd8};
        logic [3:0] ops1[4] = '{4'd1, 4'd6, 4'd9, 4'd15};
        int order[4];
        bit ok;
`ifdef ALU_ARB_FIXED_PRIO_EN
        order = '{0, 0, 0, 0};
`else
        order = '{0, 1, 0, 1};
`endif
        do_reset();
        both_ready = 0;
        for (int i = 0; i < 4; i++) begin
            q0.push_back({ops0[i], W'($urandom), W'($urandom)});
            q1.push_back({ops1[i], W'($urandom), W'($urandom)});
        end
        apply();
        for (int i = 0; i < 60 && (grant_q.size() - g_rd) < 4; i++) step();
        q0.delete();
        q1.delete();
        apply();
        wait_resp(4, 40, ok);
        checks++;
        if (!ok || grant_q.size() - g_rd != 4) begin
            failures++;
            $display("FAIL rr_timeout got grants=%0d responses=%0d want 4/4",
                     grant_q.size() - g_rd, got_q.size() - got_rd);
        end
        for (int i = 0; i < 4 && g_rd < grant_q.size() && got_rd < got_q.size(); i++) begin
            checks++;
            if (grant_q[g_rd] != order[i]) begin
                failures++;
                $display("FAIL rr_grant%0d got %0d want %0d", i, grant_q[g_rd], order[i]);
            end
            checks++;
            if (got_q[got_rd] !== exp_q[exp_rd]) begin
                failures++;
                $display("FAIL rr_resp%0d got %h want %h", i, got_q[got_rd], exp_q[exp_rd]);
            end
            g_rd++;
            got_rd++;
            exp_rd++;
        end
        checks++;
        if (both_ready != 0) begin
            failures++;
            $display("FAIL rr_both_ready got %0d cycles want 0", both_ready);
        end
    endtask

    task automatic test_backpressure();
        logic [W-1:0] a0, b0;
        logic [W+1:0] want;
        bit ok;
        a0 = W'($urandom);
        b0 = W'($urandom);
        want = alu_ref(4'd3, a0, b0);
        do_reset();
        rsp0_ready = 1'b0;
        q0.push_back({4'd3, a0, b0});
        q1.push_back({4'd4, W'($urandom), W'($urandom)});
        apply();
        for (int i = 0; i < 10 && rsp0_valid !== 1'b1; i++) step();
        for (int i = 0; i < 4; i++) begin
            checks++;
            if ({rsp0_valid, rsp0_flags, rsp0_result, req1_ready} !== {1'b1, want, 1'b0}) begin
                failures++;
                $display("FAIL bp_hold%0d got vld=%b res=%h flags=%b rdy1=%b want 1/%h/%b/0",
                         i, rsp0_valid, rsp0_result, rsp0_flags, req1_ready, want[W-1:0],
                         want[W+1:W]);
            end
            step();
        end
        rsp0_ready = 1'b1;
        step();
        checks++;
        if ({rsp0_valid, req1_ready} !== 2'b01) begin
            failures++;
            $display("FAIL bp_release got vld0=%b rdy1=%b want 0/1", rsp0_valid, req1_ready);
        end
        wait_resp(2, 20, ok);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL bp_timeout got %0d responses want 2", got_q.size() - got_rd);
        end
        for (int i = 0; i < 2 && got_rd < got_q.size(); i++) begin
            checks++;
            if (got_q[got_rd] !== exp_q[exp_rd]) begin
                failures++;
                $display("FAIL bp_resp%0d got %h want %h", i, got_q[got_rd], exp_q[exp_rd]);
            end
            got_rd++;
            exp_rd++;
        end
        g_rd = grant_q.size();
    endtask

    task automatic test_slt();
        ent_t want[2];
        bit ok;
        want[0] = {1'b1, 2'b00, 32'd1};
        want[1] = {1'b1, 2'b01, 32'd0};
        q1.push_back({4'd8, 32'hFFFF_FFFF, 32'd1});
        q1.push_back({4'd7, 32'hFFFF_FFFF, 32'd1});
        apply();
        wait_resp(2, 20, ok);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL slt_timeout got %0d responses want 2", got_q.size() - got_rd);
        end
        for (int i = 0; i < 2 && got_rd < got_q.size(); i++) begin
            checks++;
            if (got_q[got_rd] !== want[i] || exp_q[exp_rd] !== want[i]) begin
                failures++;
                $display("FAIL slt_resp%0d got %h sb %h want %h", i, got_q[got_rd],
                         exp_q[exp_rd], want[i]);
            end
            got_rd++;
            exp_rd++;
        end
        g_rd = grant_q.size();
    endtask

    task automatic test_reset_mid();
        int start;
        bit ok;
        start = grant_q.size();
        q0.push_back({4'd3, 32'd1, 32'd2});
        q0.push_back({4'd3, 32'd4, 32'd8});
        apply();
        for (int i = 0; i < 10 && grant_q.size() == start; i++) step();
        nRst = 1'b0;
        #1;
        checks++;
        if ({alu_op, alu_a, alu_b, req0_ready, req1_ready, rsp0_valid, rsp1_valid} !== '0) begin
            failures++;
            $display("FAIL mid_reset_outputs got op=%h a=%h b=%h rdy=%b%b vld=%b%b want all 0",
                     alu_op, alu_a, alu_b, req0_ready, req1_ready, rsp0_valid, rsp1_valid);
        end
        do_reset();
        for (int i = 0; i < 6; i++) begin
            checks++;
            if ({rsp0_valid, rsp1_valid} !== 2'b00) begin
                failures++;
                $display("FAIL mid_no_resp%0d got vld=%b%b want 00", i, rsp0_valid, rsp1_valid);
            end
            step();
        end
        checks++;
        if (got_q.size() != got_rd) begin
            failures++;
            $display("FAIL mid_stray got %0d responses want 0", got_q.size() - got_rd);
        end
        q1.push_back({4'd0, 32'd100, 32'd23});
        apply();
        wait_resp(1, 10, ok);
        checks++;
        if (!ok || got_q[got_rd] !== {1'b1, 2'b00, 32'd123}) begin
            failures++;
            $display("FAIL mid_recover got ok=%0d resp=%h want %h", ok,
                     ok ? got_q[got_rd] : '0, {1'b1, 2'b00, 32'd123});
        end
    endtask

    initial begin
        rsp0_ready = 1'b1;
        rsp1_ready = 1'b1;
        apply();
        test_reset();
        test_single_add();
        test_tie();
        test_round_robin();
        test_backpressure();
        test_slt();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
